// File: rtl/crc32_192bit_feeder.sv
// Packs 64-bit beats into 192-bit blocks, folds the running CRC-32 into each block and
// drives an external one-cycle 192-bit CRC LUT stage; emits the FCS or a length-error pulse.
module crc32_192bit_feeder #(
    parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic         in_last,
    output logic [191:0] lut_data,
    output logic [31:0]  lut_crc_in,
    input  logic [31:0]  lut_crc_out,
    output logic         fcs_valid,
    output logic [31:0]  fcs,
    output logic         len_err,
    output logic         busy
);

    localparam int unsigned BEAT_W  = 64;
    localparam int unsigned BLOCK_W = 192;
    localparam int unsigned CRC_W   = 32;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_d;
    logic [1:0]             cnt;
    logic [2*BEAT_W-1:0]    buffer;   // beats 0 and 1; beat 2 goes straight into lut_data
    logic [CRC_W-1:0]       crc_reg;
    logic                   last_blk;

    logic accept_c;
    logic block_done_c;
    logic short_last_c;

    assign accept_c     = in_valid & in_ready;
    assign block_done_c = accept_c & (cnt == 2'd2);
    assign short_last_c = accept_c & in_last & (cnt != 2'd2);
    assign lut_crc_in   = CRC_W'(0);

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            COLLECT: if (block_done_c) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // State register with handshake/busy flags decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= COLLECT;
            in_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            in_ready <= (state_d == COLLECT);
            busy     <= (state_d != COLLECT);
        end
    end

    // Beat packing, CRC feedback and frame completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 2'd0;
            buffer    <= '0;
            crc_reg   <= CRC_INIT;
            last_blk  <= 1'b0;
            lut_data  <= '0;
            fcs       <= '0;
            fcs_valid <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            fcs_valid <= 1'b0;
            len_err   <= 1'b0;

            if (accept_c) begin
                case (cnt)
                    2'd0:    buffer[BEAT_W-1:0]        <= in_data;
                    2'd1:    buffer[2*BEAT_W-1:BEAT_W] <= in_data;
                    default: ;
                endcase

                if (in_last || cnt == 2'd2) cnt <= 2'd0;
                else                        cnt <= cnt + 2'd1;

                if (block_done_c) begin
                    lut_data <= {in_data, buffer} ^ BLOCK_W'(crc_reg);
                    last_blk <= in_last;
                end

                // Short frame: partial block is dropped and the CRC restarts
                if (short_last_c) begin
                    len_err <= 1'b1;
                    crc_reg <= CRC_INIT;
                end
            end

            if (state == WAIT) begin
                if (last_blk) begin
                    fcs       <= lut_crc_out ^ CRC_XOROUT;
                    fcs_valid <= 1'b1;
                    crc_reg   <= CRC_INIT;
                end else begin
                    crc_reg   <= lut_crc_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc32_192bit_feeder.sv
// Bench for crc32_192bit_feeder: behavioural LUT stage, frame-level bit-serial CRC-32 model,
// table-driven frames, randomized frames and a reset-during-WAIT sequence.
module tb_crc32_192bit_feeder;

    localparam logic [31:0] POLY = 32'hEDB88320;
    localparam logic [31:0] INIT = 32'hFFFFFFFF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic [191:0] lut_data;
    logic [31:0]  lut_crc_in;
    logic [31:0]  lut_crc_out = '0;
    logic         fcs_valid;
    logic [31:0]  fcs;
    logic         len_err;
    logic         busy;

    crc32_192bit_feeder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .lut_data   (lut_data),
        .lut_crc_in (lut_crc_in),
        .lut_crc_out(lut_crc_out),
        .fcs_valid  (fcs_valid),
        .fcs        (fcs),
        .len_err    (len_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reflected CRC-32, one bit at a time, bit 0 of d first
    function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [63:0] d, input int n);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < n; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ POLY;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // External LUT stage: plain CRC of the 192-bit block from a zero register, one clk latency
    always @(posedge clk)
        lut_crc_out <= crc_bits(crc_bits(crc_bits(32'h0, lut_data[63:0], 64),
                                         lut_data[127:64], 64), lut_data[191:128], 64);

    typedef struct {
        bit          is_err;
        logic [31:0] fcs;
        int          due;
    } ev_t;

    ev_t          exp_ev[$];
    logic [191:0] exp_lut[$];
    logic [31:0]  run_crc = INIT;
    logic [31:0]  blk_crc = INIT;
    logic [63:0]  blk[3];
    int           blk_n = 0;
    int           frame_n = 0;
    logic [31:0]  held_fcs = '0;
    int           issues = 0;
    int           fcs_seen = 0;
    int           err_seen = 0;

    // Frame-level model, advanced on every accepted beat
    task automatic model_accept(input logic [63:0] d, input bit last);
        ev_t e;
        if (blk_n == 0) blk_crc = run_crc;
        blk[blk_n] = d;
        run_crc = crc_bits(run_crc, d, 64);
        frame_n++;
        if (blk_n == 2) begin
            exp_lut.push_back({d, blk[1], blk[0]} ^ 192'(blk_crc));
            blk_n = 0;
        end else begin
            blk_n++;
        end
        if (last) begin
            e.is_err = (frame_n % 3) != 0;
            e.fcs    = run_crc ^ 32'hFFFFFFFF;
            e.due    = cyc + (e.is_err ? 1 : 3);
            exp_ev.push_back(e);
            run_crc = INIT;
            blk_n   = 0;
            frame_n = 0;
        end
    endtask

    logic         busy_q = 1'b0;
    logic [191:0] lut_prev = '0;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            lut_prev <= '0;
        end else begin
            ev_t e;
            chk("ready_vs_busy", 192'(in_ready), 192'(!busy));
            if (fcs_valid && len_err) chk("fcs_valid_and_len_err", 192'(1), 192'(0));
            if (!busy) chk("lut_data_hold", lut_data, lut_prev);
            if (busy && !busy_q) begin
                issues++;
                if (exp_lut.size() == 0) chk("unexpected_issue", 192'(1), 192'(0));
                else chk("lut_data_block", lut_data, exp_lut.pop_front());
            end
            if (fcs_valid || len_err) begin
                if (exp_ev.size() == 0) begin
                    chk("unexpected_event", {fcs_valid, len_err}, 192'(0));
                end else begin
                    e = exp_ev.pop_front();
                    chk("event_kind_err", 192'(len_err), 192'(e.is_err));
                    chk("event_cycle", 192'(cyc), 192'(e.due));
                    if (fcs_valid) begin
                        fcs_seen++;
                        chk("fcs_value", 192'(fcs), 192'(e.fcs));
                        held_fcs = e.fcs;
                    end else begin
                        err_seen++;
                    end
                end
            end
            if (!fcs_valid) chk("fcs_hold", 192'(fcs), 192'(held_fcs));
            if (exp_ev.size() > 0 && cyc > exp_ev[0].due) begin
                chk("event_overdue", 192'(cyc), 192'(exp_ev[0].due));
                void'(exp_ev.pop_front());
            end
            busy_q   <= busy;
            lut_prev <= lut_data;
        end
    end

    // Offer one beat after `gaps` idle cycles; hold it until accepted
    task automatic send_beat(input logic [63:0] d, input bit last, input int gaps);
        bit rdy;
        int n;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (gaps) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = in_ready;
            if (rdy) model_accept(d, last);
            @(posedge clk); #1;
            n++;
        end
        if (!rdy) chk("accept_timeout", 192'(0), 192'(1));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        exp_ev.delete();
        exp_lut.delete();
        run_crc  = INIT;
        blk_n    = 0;
        frame_n  = 0;
        held_fcs = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic post_reset_checks();
        @(negedge clk);
        chk("rst_in_ready", 192'(in_ready), 192'(1));
        chk("rst_busy", 192'(busy), 192'(0));
        chk("rst_fcs", 192'(fcs), 192'(0));
        chk("rst_lut_data", lut_data, 192'(0));
        chk("rst_fcs_valid", 192'(fcs_valid), 192'(0));
        chk("rst_len_err", 192'(len_err), 192'(0));
        @(posedge clk); #1;
    endtask

    typedef struct {
        int unsigned nbeats;
        bit          zero_data;
        int unsigned max_gap;
        bit          drain;
        int unsigned exp_issues;
        int unsigned exp_fcs;
        int unsigned exp_err;
    } vec_t;

    localparam int NV = 10;
    vec_t vt[NV];

    int exp_issues = 0;
    int exp_fcs_n  = 0;
    int exp_err_n  = 0;

    task automatic run_frame(input int unsigned nb, input bit zero, input int unsigned max_gap);
        logic [63:0] d;
        for (int b = 0; b < int'(nb); b++) begin
            d = zero ? 64'h0 : {$urandom, $urandom};
            send_beat(d, b == int'(nb) - 1, (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
        end
    endtask

    task automatic drain_and_count(input string tag);
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_issues"}, 192'(issues), 192'(exp_issues));
        chk({tag, "_fcs_count"}, 192'(fcs_seen), 192'(exp_fcs_n));
        chk({tag, "_err_count"}, 192'(err_seen), 192'(exp_err_n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] c;
        logic [63:0] w0;
        logic [63:0] w1;

        // Model sanity: CRC-32 of "123456789"
        w0 = 64'h3837363534333231;
        w1 = 64'h39;
        c = crc_bits(crc_bits(INIT, w0, 64), w1, 8) ^ 32'hFFFFFFFF;
        chk("model_check_value", 192'(c), 192'(32'hCBF43926));

        //        nbeats zero gap drain issues fcs err
        vt[0] = '{3, 1'b1, 0, 1'b1, 1, 1, 0};   // all-zero frame
        vt[1] = '{2, 1'b0, 0, 1'b1, 0, 0, 1};   // short frame
        vt[2] = '{3, 1'b0, 0, 1'b1, 1, 1, 0};   // frame after short frame
        vt[3] = '{6, 1'b0, 3, 1'b1, 2, 1, 0};   // two blocks, gapped valid
        vt[4] = '{3, 1'b0, 0, 1'b0, 1, 1, 0};   // back-to-back pair
        vt[5] = '{3, 1'b0, 0, 1'b1, 1, 1, 0};
        vt[6] = '{1, 1'b0, 0, 1'b1, 0, 0, 1};   // single beat
        vt[7] = '{9, 1'b0, 2, 1'b1, 3, 1, 0};
        vt[8] = '{4, 1'b0, 1, 1'b1, 1, 0, 1};   // last at counter 0 after a full block
        vt[9] = '{5, 1'b0, 0, 1'b1, 1, 0, 1};   // last at counter 1 after a full block

        do_reset();
        post_reset_checks();

        // Zero frame: block presented with feedback only in the low 32 bits
        send_beat(64'h0, 1'b0, 0);
        send_beat(64'h0, 1'b0, 0);
        send_beat(64'h0, 1'b1, 0);
        @(negedge clk);
        chk("zero_issue_busy", 192'(busy), 192'(1));
        chk("zero_issue_ready", 192'(in_ready), 192'(0));
        chk("zero_issue_lut", lut_data, 192'(32'hFFFFFFFF));
        @(negedge clk);
        chk("zero_wait_busy", 192'(busy), 192'(1));
        chk("zero_wait_lut", lut_data, 192'(32'hFFFFFFFF));
        @(posedge clk); #1;
        exp_issues += 1;
        exp_fcs_n  += 1;
        drain_and_count("zero_frame");

        for (int t = 0; t < NV; t++) begin
            run_frame(vt[t].nbeats, vt[t].zero_data, vt[t].max_gap);
            exp_issues += int'(vt[t].exp_issues);
            exp_fcs_n  += int'(vt[t].exp_fcs);
            exp_err_n  += int'(vt[t].exp_err);
            if (vt[t].drain) drain_and_count($sformatf("vec%0d", t));
        end

        // Randomized frames
        for (int r = 0; r < 25; r++) begin
            int unsigned nb;
            nb = $urandom_range(9, 1);
            run_frame(nb, 1'b0, $urandom_range(2, 0));
            exp_issues += int'(nb / 3);
            if (nb % 3 == 0) exp_fcs_n++;
            else             exp_err_n++;
        end
        drain_and_count("random");

        // Reset in WAIT of a final block: the frame is abandoned silently
        send_beat({$urandom, $urandom}, 1'b0, 0);
        send_beat({$urandom, $urandom}, 1'b0, 0);
        send_beat({$urandom, $urandom}, 1'b1, 0);
        @(posedge clk); #1;
        chk("abort_in_wait_busy", 192'(busy), 192'(1));
        do_reset();
        exp_issues += 1;
        post_reset_checks();
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_fcs", 192'(fcs_seen), 192'(exp_fcs_n));
        chk("abort_no_err", 192'(err_seen), 192'(exp_err_n));
        run_frame(3, 1'b0, 0);
        exp_issues += 1;
        exp_fcs_n  += 1;
        drain_and_count("after_abort");

        chk("pending_events", 192'(exp_ev.size()), 192'(0));
        chk("pending_blocks", 192'(exp_lut.size()), 192'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crc32_192bit_feeder.md
CRC32_192BIT_FEEDER -- requirements
Module: crc32_192bit_feeder

Interface
REQ-001 Parameter: CRC_INIT, 32'hFFFFFFFF, running-CRC start value loaded at reset and at every frame start.
REQ-002 Parameter: CRC_XOROUT, 32'hFFFFFFFF, value XORed onto the final running CRC to form the FCS.
REQ-003 Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid & in_ready.
- in_data  input  64  payload beat; bit 0 is first in transmission order.
- in_last  input  1  qualifies the final beat of a frame.
- lut_data  output  192  block presented to the 192-bit CRC LUT stage.
- lut_crc_in  output  32  crc_in of the LUT stage; constant 32'h0.
- lut_crc_out  input  32  LUT stage result, valid one clk after lut_data is presented.
- fcs_valid  output  1  one-cycle pulse, fcs valid.
- fcs  output  32  frame check sequence.
- len_err  output  1  one-cycle pulse, frame not a multiple of 3 beats.
- busy  output  1  high while a block is in ISSUE or WAIT.

Function
REQ-004 Beats pack into a 192-bit buffer: beat k (k=0,1,2) of a block occupies bits [64k+63:64k].
REQ-005 A 2-bit beat counter counts 0..2; it wraps to 0 after the third beat or after any in_last.
REQ-006 States: COLLECT, ISSUE, WAIT.
- COLLECT: in_ready=1.
- ISSUE: one cycle, in_ready=0, busy=1.
- WAIT: one cycle, in_ready=0, busy=1.
REQ-007 COLLECT -> ISSUE when the third beat (counter==2) is accepted; otherwise stay in COLLECT.
REQ-008 ISSUE -> WAIT unconditionally.
REQ-009 WAIT -> COLLECT unconditionally.
REQ-010 In ISSUE and WAIT, lut_data = buffer ^ {160'h0, crc_reg}; reflected-CRC feedback folds into the first 32 block bits.
REQ-011 In COLLECT, lut_data holds its last value; it changes only on entry to ISSUE.
REQ-012 In WAIT, crc_reg <= lut_crc_out (one-cycle LUT latency).
REQ-013 Throughput: 3 beats per 5 cycles maximum; no block overlaps another.
REQ-014 Final beat at counter==2:
- the block is processed normally;
- in WAIT, fcs <= lut_crc_out ^ CRC_XOROUT and fcs_valid pulses on the next cycle;
- crc_reg <= CRC_INIT in the same WAIT cycle.
REQ-015 Final beat at counter 0 or 1:
- block discarded, no ISSUE;
- len_err pulses on the next cycle;
- crc_reg <= CRC_INIT;
- counter <= 0;
- fcs_valid stays 0 and fcs holds its previous value.
REQ-016 fcs holds its value until the next fcs_valid.
REQ-017 fcs_valid and len_err are never asserted together.
REQ-018 Back-to-back frames: a beat offered in the cycle after WAIT is accepted and starts the new frame with crc_reg=CRC_INIT.
REQ-019 in_valid while in_ready=0 is ignored; upstream holds the beat (standard valid/ready).
REQ-020 lut_crc_in is tied to 32'h0 at all times.

Reset
REQ-021 rst_n low asynchronously forces:
- state=COLLECT, counter=0, buffer=0, crc_reg=CRC_INIT;
- lut_data=0, fcs=0, fcs_valid=0, len_err=0, busy=0.
REQ-022 After deassertion, in_ready=1 on the first clk.
REQ-023 Reset during ISSUE or WAIT aborts the block; no fcs_valid and no len_err are emitted for it.

Verification
REQ-024 Reset release, in_valid=0 -> in_ready=1, busy=0, fcs=0, lut_data=0.
REQ-025 One frame of 3 beats of 64'h0, last on beat 3 ->
- lut_data[31:0]=32'hFFFFFFFF, all other bits 0, during ISSUE/WAIT;
- fcs_valid pulses exactly 5 cycles after the first accepted beat;
- fcs equals a bit-serial CRC-32 (802.3) model over 24 zero bytes.
REQ-026 Frame of 2 beats, last on beat 2 -> len_err pulse 1 cycle later, no fcs_valid, no ISSUE; the next 3-beat frame yields the model CRC.
REQ-027 6-beat frame with random data and in_valid toggled randomly ->
- two ISSUE/WAIT pairs;
- in_ready=0 in both;
- fcs matches the model.
REQ-028 Two 3-beat frames back-to-back with in_valid held high -> two fcs_valid pulses 5 cycles apart, each matching its own model CRC (INIT reload checked).
REQ-029 rst_n asserted in WAIT of a final block -> no fcs_valid; after release, crc_reg behaves as CRC_INIT (next frame matches the model).
